// File: rtl/csa_pkg.sv
// Shared constants and the stage-1 per-block record for the pipelined carry-select adder.
package csa_pkg;

  localparam int unsigned CSA_WIDTH   = 16;
  localparam int unsigned CSA_BLK     = 4;
  // Widest block the stage-1 record can carry; narrower blocks use the low bits.
  localparam int unsigned CSA_BLK_MAX = 32;

  typedef struct packed {
    logic [CSA_BLK_MAX-1:0] sum0;
    logic [CSA_BLK_MAX-1:0] sum1;
    logic                   c0;
    logic                   c1;
  } blk_cand_t;

endpackage

// File: rtl/csa_block.sv
// BLK-bit dual ripple adder: produces the block sum and carry for both possible carry-ins.
module csa_block
  import csa_pkg::*;
#(
  parameter int unsigned BLK = CSA_BLK
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  output logic [BLK-1:0] sum0,
  output logic [BLK-1:0] sum1,
  output logic           c0,
  output logic           c1
);

  logic r0;
  logic r1;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sum0 = '0;
    sum1 = '0;
    r0   = 1'b0;
    r1   = 1'b1;
    for (int i = 0; i < int'(BLK); i++) begin
      sum0[i] = a[i] ^ b[i] ^ r0;
      sum1[i] = a[i] ^ b[i] ^ r1;
      r0      = (a[i] & b[i]) | (r0 & (a[i] ^ b[i]));
      r1      = (a[i] & b[i]) | (r1 & (a[i] ^ b[i]));
    end
    c0 = r0;
    c1 = r1;
  end

endmodule

// File: rtl/pipe_csa_adder.sv
// Two-stage valid/ready carry-select adder: stage 1 registers per-block candidates, stage 2 resolves the select chain.
// Optional signed-overflow output OVF is built only when CSA_OVF_EN is defined.
module pipe_csa_adder
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = CSA_WIDTH,
  parameter int unsigned BLK   = CSA_BLK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C_out
`ifdef CSA_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int unsigned NBLK = WIDTH / BLK;

  if ((WIDTH % BLK) != 0 || BLK > CSA_BLK_MAX) begin : g_cfg_check
    $error("pipe_csa_adder: WIDTH must be a multiple of BLK, and BLK must not exceed CSA_BLK_MAX");
  end

  logic v1;
  logic v2;
  logic adv1;
  logic adv2;

  // A stage may take new data when it is empty or its contents move on this cycle.
  assign adv2      = !v2 || out_ready;
  assign adv1      = !v1 || adv2;
  assign in_ready  = rst_n && adv1;
  assign out_valid = v2;

  blk_cand_t        cand [NBLK];
  blk_cand_t        st1  [NBLK];
  logic             cin1;
  logic [NBLK:0]    chain;
  logic [WIDTH-1:0] s_next;

  assign chain[0] = cin1;

  for (genvar i = 0; i < int'(NBLK); i++) begin : g_blk
    logic [BLK-1:0] sum0;
    logic [BLK-1:0] sum1;
    logic           c0;
    logic           c1;

    csa_block #(.BLK(BLK)) u_blk (
      .a   (A[i*BLK +: BLK]),
      .b   (B[i*BLK +: BLK]),
      .sum0(sum0),
      .sum1(sum1),
      .c0  (c0),
      .c1  (c1)
    );

    assign cand[i] = '{sum0: CSA_BLK_MAX'(sum0), sum1: CSA_BLK_MAX'(sum1), c0: c0, c1: c1};

    // Select chain: block i picks its candidate with the resolved carry out of block i-1.
    assign chain[i+1]             = chain[i] ? st1[i].c1 : st1[i].c0;
    assign s_next[i*BLK +: BLK]   = chain[i] ? st1[i].sum1[BLK-1:0] : st1[i].sum0[BLK-1:0];

    if (BLK < CSA_BLK_MAX) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^{st1[i].sum0[CSA_BLK_MAX-1:BLK], st1[i].sum1[CSA_BLK_MAX-1:BLK]};
    end
  end

`ifdef CSA_OVF_EN
  logic a_msb1;
  logic b_msb1;
  logic ovf_next;
  // Carry into the MSB recovered from the sum bit, compared against the carry out.
  assign ovf_next = (s_next[WIDTH-1] ^ a_msb1 ^ b_msb1) ^ chain[NBLK];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (adv1) v1 <= in_valid;
      if (adv2) v2 <= v1;
    end
  end

  // NOTE: stage-1 data registers carry no reset; their contents only matter while v1 is set.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      st1  <= cand;
      cin1 <= C_in;
`ifdef CSA_OVF_EN
      a_msb1 <= A[WIDTH-1];
      b_msb1 <= B[WIDTH-1];
`endif
    end
  end

  // Result registers are reset so the outputs read zero until the first result arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      S     <= '0;
      C_out <= 1'b0;
`ifdef CSA_OVF_EN
      OVF   <= 1'b0;
`endif
    end else if (adv2 && v1) begin
      S     <= s_next;
      C_out <= chain[NBLK];
`ifdef CSA_OVF_EN
      OVF   <= ovf_next;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_csa_adder.sv
// Scoreboard bench for pipe_csa_adder: directed 16-bit vectors, 4-bit exhaustive, 8-bit overflow vectors, 32-bit random handshakes.
module tb_pipe_csa_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- 16-bit DUT (default parameters) ----------------
  logic        v16 = 0, r16, c16 = 0, ov16, or16 = 1, co16, ovf16;
  logic [15:0] a16 = 0, b16 = 0, s16;
  logic [17:0] q16[$];
  logic [17:0] e16;
  logic        stall16 = 0;
  logic [16:0] held16;

  pipe_csa_adder u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16), .A(a16), .B(b16), .C_in(c16),
    .out_valid(ov16), .out_ready(or16), .S(s16), .C_out(co16)
`ifdef CSA_OVF_EN
    , .OVF(ovf16)
`endif
  );
`ifndef CSA_OVF_EN
  assign ovf16 = 1'b0;
`endif

  always begin
    @(negedge clk); #2;
    if (!rst_n) stall16 = 0;
    else begin
      if (stall16) check("d16_stall_hold", {ov16, co16, s16}, {1'b1, held16});
      if (ov16 && or16) begin
        if (q16.size() == 0) begin
          checks++; errors++;
          $display("FAIL d16_unexpected: got %0h expected none", {co16, s16});
        end else begin
          e16 = q16.pop_front();
          check("d16_sum", {co16, s16}, e16[16:0]);
`ifdef CSA_OVF_EN
          check("d16_ovf", ovf16, e16[17]);
`endif
        end
      end
      stall16 = ov16 && !or16;
      held16  = {co16, s16};
    end
  end

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic [17:0] exp);
    a16 = a; b16 = b; c16 = cin; v16 = 1'b1;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (r16) begin
        q16.push_back(exp);
        @(negedge clk);
        v16 = 1'b0;
        return;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL d16_accept_timeout: got in_ready=0 expected 1 within 20 cycles");
    v16 = 1'b0;
  endtask

  // ---------------- 4-bit DUT (WIDTH=4, BLK=4) ----------------
  logic       v4 = 0, r4, c4 = 0, ov4, co4, ovf4;
  logic [3:0] a4 = 0, b4 = 0, s4;
  logic [5:0] q4[$];
  logic [5:0] e4;

  pipe_csa_adder #(.WIDTH(4), .BLK(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .A(a4), .B(b4), .C_in(c4),
    .out_valid(ov4), .out_ready(1'b1), .S(s4), .C_out(co4)
`ifdef CSA_OVF_EN
    , .OVF(ovf4)
`endif
  );
`ifndef CSA_OVF_EN
  assign ovf4 = 1'b0;
`endif

  always begin
    @(negedge clk); #2;
    if (rst_n && ov4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL d4_unexpected: got %0h expected none", {co4, s4});
      end else begin
        e4 = q4.pop_front();
        check("d4_sum", {co4, s4}, e4[4:0]);
`ifdef CSA_OVF_EN
        check("d4_ovf", ovf4, e4[5]);
`endif
      end
    end
  end

  // ---------------- 8-bit DUT (overflow vectors) ----------------
  logic       v8 = 0, r8, c8 = 0, ov8, co8, ovf8;
  logic [7:0] a8 = 0, b8 = 0, s8;
  logic [9:0] q8[$];
  logic [9:0] e8;

  pipe_csa_adder #(.WIDTH(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .A(a8), .B(b8), .C_in(c8),
    .out_valid(ov8), .out_ready(1'b1), .S(s8), .C_out(co8)
`ifdef CSA_OVF_EN
    , .OVF(ovf8)
`endif
  );
`ifndef CSA_OVF_EN
  assign ovf8 = 1'b0;
`endif

  always begin
    @(negedge clk); #2;
    if (rst_n && ov8) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL d8_unexpected: got %0h expected none", {co8, s8});
      end else begin
        e8 = q8.pop_front();
        check("d8_sum", {co8, s8}, e8[8:0]);
`ifdef CSA_OVF_EN
        check("d8_ovf", ovf8, e8[9]);
`endif
      end
    end
  end

  // ---------------- 32-bit DUT (WIDTH=32, BLK=8) ----------------
  logic        v32 = 0, r32, c32 = 0, ov32, or32 = 1, co32, ovf32;
  logic [31:0] a32 = 0, b32 = 0, s32;
  logic [33:0] q32[$];
  logic [33:0] e32;
  logic        stall32 = 0;
  logic [32:0] held32;

  pipe_csa_adder #(.WIDTH(32), .BLK(8)) u_d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32), .A(a32), .B(b32), .C_in(c32),
    .out_valid(ov32), .out_ready(or32), .S(s32), .C_out(co32)
`ifdef CSA_OVF_EN
    , .OVF(ovf32)
`endif
  );
`ifndef CSA_OVF_EN
  assign ovf32 = 1'b0;
`endif

  always begin
    @(negedge clk); #2;
    if (!rst_n) stall32 = 0;
    else begin
      if (stall32) check("d32_stall_hold", {ov32, co32, s32}, {1'b1, held32});
      if (ov32 && or32) begin
        if (q32.size() == 0) begin
          checks++; errors++;
          $display("FAIL d32_unexpected: got %0h expected none", {co32, s32});
        end else begin
          e32 = q32.pop_front();
          check("d32_sum", {co32, s32}, e32[32:0]);
`ifdef CSA_OVF_EN
          check("d32_ovf", ovf32, e32[33]);
`endif
        end
      end
      stall32 = ov32 && !or32;
      held32  = {co32, s32};
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before 400000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0]  s5;
    logic [32:0] s33;

    // Reset state.
    repeat (2) @(negedge clk);
    v16 = 1'b1; #1;
    check("rst_in_ready", r16, 1'b0);
    check("rst_out_valid", ov16, 1'b0);
    v16 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("post_rst_out_valid", ov16, 1'b0);
    check("post_rst_sum", {co16, s16}, 17'h0);
    check("post_rst_in_ready", r16, 1'b1);
    @(negedge clk);

    // Full carry ripple and two-cycle latency.
    issue16(16'hFFFF, 16'h0000, 1'b1, {1'b0, 1'b1, 16'h0000});
    #1 check("lat_not_yet", ov16, 1'b0);
    @(negedge clk); #1;
    check("lat_valid", ov16, 1'b1);
    check("lat_sum", {co16, s16}, {1'b1, 16'h0000});
    @(negedge clk);

    // Back-to-back directed vectors.
    issue16(16'h1234, 16'h4321, 1'b0, {1'b0, 1'b0, 16'h5555});
    issue16(16'h8000, 16'h8000, 1'b0, {1'b1, 1'b1, 16'h0000});
    issue16(16'h7FFF, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h8000});
    issue16(16'h0F0F, 16'h00F1, 1'b0, {1'b0, 1'b0, 16'h1000});
    issue16(16'hABCD, 16'h1234, 1'b1, {1'b0, 1'b0, 16'hBE02});
    repeat (4) @(negedge clk);

    // Stall with both stages full.
    issue16(16'd1, 16'd1, 1'b0, 18'd2);
    issue16(16'd2, 16'd2, 1'b0, 18'd4);
    or16 = 1'b0;
    a16 = 16'd3; b16 = 16'd3; c16 = 1'b0; v16 = 1'b1;
    #1 check("stall_ready_0", r16, 1'b0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); #1;
      check("stall_ready", r16, 1'b0);
    end
    @(negedge clk);
    or16 = 1'b1;
    #1 check("release_ready", r16, 1'b1);
    if (r16) q16.push_back(18'd6);
    @(negedge clk);
    v16 = 1'b0;
    repeat (4) @(negedge clk);
    check("d16_drained", q16.size(), 0);

    // Reset with two operations in flight.
    issue16(16'd11, 16'd22, 1'b0, 18'd33);
    issue16(16'd5, 16'd5, 1'b0, 18'd10);
    rst_n = 1'b0;
    q16.delete();
    v16 = 1'b1;
    #1 check("mid_rst_in_ready", r16, 1'b0);
    v16 = 1'b0;
    @(negedge clk); #1;
    check("mid_rst_out_valid", ov16, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1 check("mid_rst_no_output", ov16, 1'b0);
    @(negedge clk);

    // Exhaustive 4-bit, one operation per cycle.
    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          a4 = 4'(a); b4 = 4'(b); c4 = c[0]; v4 = 1'b1;
          s5 = 5'(a) + 5'(b) + 5'(c);
          #1 check("d4_ready", r4, 1'b1);
          if (r4) q4.push_back({(a4[3] == b4[3]) && (s5[3] != a4[3]), s5});
          @(negedge clk);
        end
      end
    end
    v4 = 1'b0;
    repeat (4) @(negedge clk);
    check("d4_drained", q4.size(), 0);

    // 8-bit overflow vectors.
    a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0; v8 = 1'b1;
    #1 if (r8) q8.push_back({1'b1, 1'b0, 8'h80});
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0;
    #1 if (r8) q8.push_back({1'b0, 1'b1, 8'h00});
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; c8 = 1'b0;
    #1 if (r8) q8.push_back({1'b1, 1'b1, 8'h00});
    @(negedge clk);
    v8 = 1'b0;
    repeat (4) @(negedge clk);
    check("d8_drained", q8.size(), 0);

    // Randomised handshakes at WIDTH=32, BLK=8.
    for (int n = 0; n < 400; n++) begin
      v32  = ($urandom_range(0, 9) < 7);
      or32 = ($urandom_range(0, 9) < 6);
      a32  = $urandom;
      b32  = $urandom;
      c32  = $urandom_range(0, 1) == 1;
      s33  = {1'b0, a32} + {1'b0, b32} + 33'(c32);
      #1 if (v32 && r32) q32.push_back({(a32[31] == b32[31]) && (s33[31] != a32[31]), s33});
      @(negedge clk);
    end
    v32  = 1'b0;
    or32 = 1'b1;
    for (int t = 0; t < 20 && q32.size() != 0; t++) @(negedge clk);
    check("d32_drained", q32.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
